mdu_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the combinational ALU in the execute stage. Takes one operation at a time over a valid/ready handshake and returns a tagged result over a second valid/ready handshake.
- Supports a synchronous pipeline flush.

---
 rtl/mdu_unit.sv | 158 +++++++++++++++
 tb/tb_mdu_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, sign fix-up in a separate cycle, tagged result with backpressure.
module mdu_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             op_valid_in,
  output logic             op_ready_out,
  input  logic [XLEN-1:0]  op_1_in,
  input  logic [XLEN-1:0]  op_2_in,
  input  logic [2:0]       opcode_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush_in,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic [XLEN-1:0]  result_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   a;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod;     // mul: {hi, lo} product; div: {remainder, quotient}
  logic              is_div;
  logic              sel_hi;   // mul: return high half; div: return remainder
  logic              neg_res;

  // request decode
  logic            sgn_1, sgn_2, neg_1, neg_2, neg_req;
  logic [XLEN-1:0] mag_1, mag_2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  // per-step datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_diff;
  logic [2*XLEN-1:0] div_next;

  // sign fix-up
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_raw;
  logic [XLEN-1:0]   fix_res;

  // Decode signedness, magnitudes and fast-path special cases of the request
  always_comb begin
    if (opcode_in[2]) begin
      sgn_1 = ~opcode_in[0];
      sgn_2 = ~opcode_in[0];
    end else begin
      sgn_1 = (opcode_in[1:0] != 2'b11);
      sgn_2 = ~opcode_in[1];
    end
    neg_1 = sgn_1 & op_1_in[XLEN-1];
    neg_2 = sgn_2 & op_2_in[XLEN-1];
    mag_1 = neg_1 ? ('0 - op_1_in) : op_1_in;
    mag_2 = neg_2 ? ('0 - op_2_in) : op_2_in;
    // remainder follows the dividend; products and quotients follow the sign xor
    if (opcode_in[2] && opcode_in[1]) neg_req = neg_1;
    else                              neg_req = neg_1 ^ neg_2;
    div_zero = opcode_in[2] && (op_2_in == '0);
    div_ovf  = opcode_in[2] && !opcode_in[0] && (op_1_in == MOST_NEG) && (op_2_in == '1);
    if (div_zero) fast_res = opcode_in[1] ? op_1_in : '1;
    else          fast_res = opcode_in[1] ? '0 : op_1_in;
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a} : '0);
    mul_next = {mul_sum, prod[XLEN-1:1]};
    rem_sh   = prod[2*XLEN-1:XLEN-1];
    rem_ge   = (rem_sh >= {1'b0, a});
    // the difference is below the divisor, so the dropped top bit is always zero
    rem_diff = rem_sh[XLEN-1:0] - a;
    div_next = rem_ge ? {rem_diff, prod[XLEN-2:0], 1'b1} : {prod[2*XLEN-2:0], 1'b0};
  end

  // Final sign correction and result selection
  always_comb begin
    // a product is negated over its full width so the high half gets the borrow
    prod_fix = neg_res ? ('0 - prod) : prod;
    div_raw  = sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    if (is_div)      fix_res = neg_res ? ('0 - div_raw) : div_raw;
    else if (sel_hi) fix_res = prod_fix[2*XLEN-1:XLEN];
    else             fix_res = prod_fix[XLEN-1:0];
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      cnt              <= '0;
      a                <= '0;
      prod             <= '0;
      is_div           <= 1'b0;
      sel_hi           <= 1'b0;
      neg_res          <= 1'b0;
      op_ready_out     <= 1'b1;
      result_valid_out <= 1'b0;
      result_out       <= '0;
      tag_out          <= '0;
    end else if (flush_in) begin
      state            <= IDLE;
      op_ready_out     <= 1'b1;
      result_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid_in) begin
            tag_out      <= tag_in;
            is_div       <= opcode_in[2];
            sel_hi       <= opcode_in[2] ? opcode_in[1] : (opcode_in[1:0] != 2'b00);
            neg_res      <= neg_req;
            op_ready_out <= 1'b0;
            if (div_zero || div_ovf) begin
              result_out       <= fast_res;
              result_valid_out <= 1'b1;
              state            <= DONE;
            end else begin
              a     <= opcode_in[2] ? mag_2 : mag_1;
              prod  <= {{XLEN{1'b0}}, (opcode_in[2] ? mag_1 : mag_2)};
              cnt   <= CW'(XLEN - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          prod <= is_div ? div_next : mul_next;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          result_out       <= fix_res;
          result_valid_out <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          if (result_ready_in) begin
            result_valid_out <= 1'b0;
            op_ready_out     <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: vector table of RV32M operations with expected
// results and latencies, plus backpressure, flush and mid-operation reset.
module tb_mdu_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             op_valid;
  logic             op_ready;
  logic [XLEN-1:0]  op_1, op_2;
  logic [2:0]       opcode;
  logic [TAG_W-1:0] tag_i;
  logic             flush;
  logic             res_valid;
  logic             res_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_o;

  int checks   = 0;
  int failures = 0;

  mdu_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .op_valid_in     (op_valid),
    .op_ready_out    (op_ready),
    .op_1_in         (op_1),
    .op_2_in         (op_2),
    .opcode_in       (opcode),
    .tag_in          (tag_i),
    .flush_in        (flush),
    .result_valid_out(res_valid),
    .result_ready_in (res_ready),
    .result_out      (result),
    .tag_out         (tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
    int               lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // present a request at the next negedge; it is accepted on the following posedge
  task automatic start_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t);
    @(negedge clk);
    opcode = op; op_1 = a; op_2 = b; tag_i = t; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_1 = '1; op_2 = '1; opcode = 3'b000; tag_i = '1;
  endtask

  // edges after the accept edge until result_valid is seen (bounded)
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  int lat;
  int seen;
  logic [XLEN-1:0]  held_res;
  logic [TAG_W-1:0] held_tag;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFF9, 5'd12, 32'hFFFFFFCF, 33};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd6,  32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd7,  32'd2,        33};
    vecs[8]  = '{3'b100, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 0};
    vecs[9]  = '{3'b111, 32'd5,        32'd0,        5'd9,  32'd5,        0};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 0};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        0};
    vecs[12] = '{3'b000, 32'd3,        32'd4,        5'd13, 32'd12,       33};
    vecs[13] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'd0,        33};
    vecs[14] = '{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd15, 32'hFFFFFFFF, 33};
    vecs[15] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 33};
    vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd17, 32'd1,        33};
    vecs[17] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        33};
    vecs[18] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 33};
    vecs[19] = '{3'b101, 32'hFFFFFFFF, 32'd1,        5'd31, 32'hFFFFFFFF, 33};

    rst_n = 1'b0; op_valid = 1'b0; op_1 = '0; op_2 = '0; opcode = '0;
    tag_i = '0; flush = 1'b0; res_ready = 1'b0;
    #12;
    chk("reset_op_ready", 32'(op_ready), 32'd1);
    chk("reset_valid", 32'(res_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_tag", 32'(tag_o), 32'd0);
    rst_n = 1'b1;

    // table-driven operations
    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_result(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), result, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), 32'(tag_o), 32'(vecs[i].tag));
      release_result();
      chk($sformatf("v%0d_valid_clr", i), 32'(res_valid), 32'd0);
      chk($sformatf("v%0d_ready_set", i), 32'(op_ready), 32'd1);
    end

    // backpressure: result held stable while consumer stalls
    start_op(3'b101, 32'd100, 32'd7, 5'd21);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'd33);
    held_res = result;
    held_tag = tag_o;
    chk("bp_result", held_res, 32'd14);
    // a new request presented during DONE must be ignored
    op_valid = 1'b1; op_1 = 32'd9; op_2 = 32'd3; opcode = 3'b000; tag_i = 5'd2;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_%0d", c), 32'(res_valid), 32'd1);
      chk($sformatf("bp_result_%0d", c), result, held_res);
      chk($sformatf("bp_tag_%0d", c), 32'(tag_o), 32'(held_tag));
      chk($sformatf("bp_op_ready_%0d", c), 32'(op_ready), 32'd0);
    end
    op_valid = 1'b0;
    release_result();
    chk("bp_release_ready", 32'(op_ready), 32'd1);
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    // no new request may have been taken on the release edge
    @(posedge clk);
    #1;
    chk("bp_no_accept", 32'(op_ready), 32'd1);

    // flush during CALC cycle 10
    start_op(3'b000, 32'd123, 32'd456, 5'd22);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_op_ready", 32'(op_ready), 32'd1);
    chk("flush_valid", 32'(res_valid), 32'd0);
    // a request presented together with flush is not accepted
    @(negedge clk);
    op_valid = 1'b1; flush = 1'b1; opcode = 3'b000; op_1 = 32'd2; op_2 = 32'd2;
    @(posedge clk);
    #1;
    op_valid = 1'b0; flush = 1'b0;
    chk("flush_req_rejected", 32'(op_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (res_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    // flush drops a result pending in DONE
    start_op(3'b100, 32'd5, 32'd0, 5'd23);
    chk("flush_done_valid_before", 32'(res_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_done_valid_after", 32'(res_valid), 32'd0);
    chk("flush_done_op_ready", 32'(op_ready), 32'd1);

    // asynchronous reset mid-CALC
    start_op(3'b000, 32'd11, 32'd13, 5'd24);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_op_ready", 32'(op_ready), 32'd1);
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_tag", 32'(tag_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(3'b000, 32'd3, 32'd4, 5'd25);
    wait_result(lat);
    chk("post_rst_latency", 32'(lat), 32'd33);
    chk("post_rst_result", result, 32'd12);
    chk("post_rst_tag", 32'(tag_o), 32'd25);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
